// File: rtl/logisim_clock_pkg.sv
// rtl/logisim_clock_pkg.sv - state encoding and phase width helper for the tick step controller
package logisim_clock_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } clk_state_e;

  // Phase width is max(1, clog2(TicksPerCycle)) so TicksPerCycle==1 still has a 1-bit register.
  function automatic int phase_w(input int ticks_per_cycle);
    int w;
    w = $clog2(ticks_per_cycle);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tick_phase_counter.sv
// rtl/tick_phase_counter.sv - tick phase within a clock cycle, wrap and cycle_done
module tick_phase_counter
  import logisim_clock_pkg::*;
#(
  parameter int TicksPerCycle = 2,
  parameter int PhaseW        = phase_w(TicksPerCycle)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  output logic cycle_done_o,
  output logic next_phase_zero_o
);

  localparam logic [PhaseW-1:0] LAST_PHASE = PhaseW'(TicksPerCycle - 1);

  logic [PhaseW-1:0] phase_q;
  logic [PhaseW-1:0] phase_d;

  always_comb begin
    cycle_done_o = tick_i && (phase_q == LAST_PHASE);
    phase_d      = phase_q;
    if (cycle_done_o) begin
      phase_d = '0;
    end else if (tick_i) begin
      phase_d = phase_q + 1'b1;
    end
    next_phase_zero_o = (phase_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/logisim_tick_step_controller.sv
// rtl/logisim_tick_step_controller.sv - run/halt/step gate for FPGATick; BREAKPOINT_EN adds a cycle breakpoint
module logisim_tick_step_controller
  import logisim_clock_pkg::*;
#(
  parameter int TicksPerCycle  = 2,
  parameter int NrOfStepBits   = 16,
  parameter int CycleCountBits = 32
) (
  input  logic                      GlobalClock,
  input  logic                      Reset,
  input  logic                      FPGATick,
  input  logic                      RunReq,
  input  logic                      HaltReq,
  input  logic                      StepReq,
  input  logic [NrOfStepBits-1:0]   StepCount,
  input  logic [CycleCountBits-1:0] BreakCycle,
  output logic                      ClockTick,
  output logic                      Running,
  output logic                      StepBusy,
  output logic                      BreakHit,
  output logic [CycleCountBits-1:0] CycleCount
);

  clk_state_e                state_q, state_d;
  logic [NrOfStepBits-1:0]   rem_q, rem_d;
  logic [CycleCountBits-1:0] cnt_q;
  logic                      bh_q, bh_d;
  logic                      cycle_done;
  logic                      next_phase_zero;
  logic                      bp_hit;
  logic                      req_acted;

  assign ClockTick  = FPGATick && (state_q != ST_HALT);
  assign Running    = (state_q != ST_HALT);
  assign StepBusy   = (state_q == ST_STEP);
  assign BreakHit   = bh_q;
  assign CycleCount = cnt_q;

  tick_phase_counter #(
    .TicksPerCycle(TicksPerCycle)
  ) u_phase (
    .clk_i            (GlobalClock),
    .rst_i            (Reset),
    .tick_i           (ClockTick),
    .cycle_done_o     (cycle_done),
    .next_phase_zero_o(next_phase_zero)
  );

`ifdef BREAKPOINT_EN
  assign bp_hit = cycle_done && ((cnt_q + 1'b1) == BreakCycle);
`else
  logic bp_unused;
  assign bp_unused = ^BreakCycle;
  assign bp_hit    = 1'b0;
`endif

  // Highest-priority asserted request wins even when its action is a no-op for the current state.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    bh_d      = bh_q;
    req_acted = 1'b0;
    if (HaltReq) begin
      req_acted = 1'b1;
      if (state_q != ST_HALT) begin
        state_d = next_phase_zero ? ST_HALT : ST_DRAIN;
      end
    end else if (StepReq) begin
      if ((state_q == ST_HALT) && (StepCount != '0)) begin
        state_d   = ST_STEP;
        rem_d     = StepCount;
        bh_d      = 1'b0;
        req_acted = 1'b1;
      end
    end else if (RunReq && (state_q != ST_RUN)) begin
      state_d   = ST_RUN;
      rem_d     = '0;
      bh_d      = 1'b0;
      req_acted = 1'b1;
    end

    if (!req_acted && cycle_done) begin
      case (state_q)
        ST_STEP: begin
          rem_d = rem_q - 1'b1;
          if (rem_q == NrOfStepBits'(1)) begin
            state_d = ST_HALT;
          end
        end
        ST_DRAIN: state_d = ST_HALT;
        ST_RUN: begin
          if (bp_hit) begin
            state_d = ST_HALT;
            bh_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge GlobalClock) begin
    if (Reset) begin
      state_q <= ST_HALT;
      rem_q   <= '0;
      cnt_q   <= '0;
      bh_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bh_q    <= bh_d;
      if (cycle_done) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logisim_tick_step_controller.sv
// tb/tb_logisim_tick_step_controller.sv - directed and randomized checks against a behavioural model
module tb_logisim_tick_step_controller;

  localparam int TPC = 2;
  localparam int SB  = 16;
  localparam int CB  = 4;
  localparam int CMOD = 1 << CB;
`ifdef BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ft = 1'b0;
  logic          run_r = 1'b0;
  logic          halt_r = 1'b0;
  logic          step_r = 1'b0;
  logic [SB-1:0] sc = '0;
  logic [CB-1:0] bc = '0;
  logic          ck_tick, running, busy, bh;
  logic [CB-1:0] cc;

  int n_tests = 0;
  int n_fail  = 0;
  int m_mode, m_ph, m_left, m_cnt, m_bh;
  int last_tick;
  int n;

  always #5 clk = ~clk;

  logisim_tick_step_controller #(
    .TicksPerCycle (TPC),
    .NrOfStepBits  (SB),
    .CycleCountBits(CB)
  ) dut (
    .GlobalClock(clk),
    .Reset      (rst),
    .FPGATick   (ft),
    .RunReq     (run_r),
    .HaltReq    (halt_r),
    .StepReq    (step_r),
    .StepCount  (sc),
    .BreakCycle (bc),
    .ClockTick  (ck_tick),
    .Running    (running),
    .StepBusy   (busy),
    .BreakHit   (bh),
    .CycleCount (cc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HALT;
    m_ph   = 0;
    m_left = 0;
    m_cnt  = 0;
    m_bh   = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model, pass the edge.
  task automatic cyc(input bit f, input bit r, input bit h, input bit s, input int scv, input bit rs);
    int  tick, done, ph_n;
    bit  acted;
    @(negedge clk);
    ft = f; run_r = r; halt_r = h; step_r = s; sc = SB'(scv); rst = rs;
    #1;
    tick = (f && m_mode != M_HALT) ? 1 : 0;
    check_eq("ClockTick", 32'(ck_tick), 32'(tick));
    check_eq("Running", 32'(running), 32'(m_mode != M_HALT));
    check_eq("StepBusy", 32'(busy), 32'(m_mode == M_STEP));
    check_eq("BreakHit", 32'(bh), 32'(m_bh));
    check_eq("CycleCount", 32'(cc), 32'(m_cnt));
    last_tick = 32'(ck_tick);
    if (rs) begin
      model_reset();
    end else begin
      done = (tick == 1 && m_ph == TPC - 1) ? 1 : 0;
      ph_n = done ? 0 : m_ph + tick;
      if (done) m_cnt = (m_cnt + 1) % CMOD;
      acted = 1'b0;
      if (h) begin
        acted = 1'b1;
        if (m_mode != M_HALT) m_mode = (ph_n == 0) ? M_HALT : M_DRAIN;
      end else if (s) begin
        if (m_mode == M_HALT && scv != 0) begin
          m_mode = M_STEP; m_left = scv; m_bh = 0; acted = 1'b1;
        end
      end else if (r && m_mode != M_RUN) begin
        m_mode = M_RUN; m_left = 0; m_bh = 0; acted = 1'b1;
      end
      if (!acted && done) begin
        if (m_mode == M_STEP) begin
          m_left--;
          if (m_left == 0) m_mode = M_HALT;
        end else if (m_mode == M_DRAIN) begin
          m_mode = M_HALT;
        end else if (m_mode == M_RUN && BP_ON && m_cnt == int'(bc)) begin
          m_mode = M_HALT; m_bh = 1;
        end
      end
      m_ph = ph_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic count_ticks(input int cycles, output int ticks);
    ticks = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      ticks += last_tick;
    end
  endtask

  initial begin
    ft = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    check_eq("rst_cc", 32'(cc), 0);
    check_eq("rst_running", 32'(running), 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    count_ticks(10, n);
    check_eq("step3_ticks", n, 6);
    check_eq("step3_cc", 32'(cc), 3);
    check_eq("step3_busy", 32'(busy), 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    count_ticks(3, n);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("drain_state_running", 32'(running), 1);
    count_ticks(5, n);
    check_eq("drain_ticks", n, 1);
    check_eq("drain_cc_even", 32'(cc[0]), 0);
    check_eq("drain_halted", 32'(running), 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    count_ticks(4, n);
    check_eq("step0_ticks", n, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    count_ticks(4, n);
    check_eq("runhalt_ticks", n, 0);
    check_eq("runhalt_running", 32'(running), 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    count_ticks(32, n);
    check_eq("wrap_cc", 32'(cc), 0);
    check_eq("wrap_running", 32'(running), 1);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    bc = CB'(5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    count_ticks(20, n);
    if (BP_ON) begin
      check_eq("bp_ticks", n, 10);
      check_eq("bp_cc", 32'(cc), 5);
      check_eq("bp_hit", 32'(bh), 1);
    end else begin
      check_eq("nobp_ticks", n, 20);
      check_eq("nobp_cc", 32'(cc), 10);
      check_eq("nobp_hit", 32'(bh), 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_eq("bp_clear", 32'(bh), 0);
    check_eq("bp_rerun", 32'(running), 1);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      int  sel;
      bit  f, r, h, s, rs;
      f = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      r = (sel == 0) || (sel == 3);
      h = (sel == 1) || (sel == 3) || (sel == 4);
      s = (sel == 2) || (sel == 4);
      rs = ($urandom_range(0, 199) == 0);
      bc = CB'($urandom_range(0, CMOD - 1));
      cyc(f, r, h, s, $urandom_range(0, 4), rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
